// File: rtl/muldiv_pkg.sv
// Shared definitions for the HI/LO multi-cycle arithmetic sequencer.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package muldiv_pkg;

  // Sequencer states
  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    INIT   = 3'd1,
    RUN    = 3'd2,
    COMMIT = 3'd3,
    EXC    = 3'd4
  } state_e;

  // Op select as carried on op_div
  localparam logic OP_MULT = 1'b0;
  localparam logic OP_DIV  = 1'b1;

  // Default geometry
  localparam int unsigned DEF_WIDTH       = 32;
  localparam int unsigned DEF_DIV_CYCLES  = 32;
  localparam int unsigned DEF_MULT_CYCLES = 32;
  localparam int unsigned DEF_CNT_W       = 6;

  // A request traps when it is a divide and the raw denominator is zero
  function automatic logic is_div_by_zero(input logic op, input logic b_is_zero);
    return (op == OP_DIV) && b_is_zero;
  endfunction

endpackage

// File: rtl/hilo_regs.sv
// Architectural HI/LO register pair with prioritised load sources.
// Latency: loads become visible the cycle after the enabling edge.
// Backpressure: none; caller gates writes by sequencer state.
module hilo_regs #(
  parameter int unsigned WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             commit_en,
  input  logic [WIDTH-1:0] commit_hi,
  input  logic [WIDTH-1:0] commit_lo,
  input  logic             mt_en,
  input  logic             hi_we,
  input  logic             lo_we,
  input  logic [WIDTH-1:0] wdata,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  logic [WIDTH-1:0] hi_q, hi_d;
  logic [WIDTH-1:0] lo_q, lo_d;

  // Next-state select: unit commit wins, MTHI/MTLO only while idle
  always_comb begin
    hi_d = hi_q;
    lo_d = lo_q;
    if (commit_en) begin
      hi_d = commit_hi;
      lo_d = commit_lo;
    end else if (mt_en) begin
      if (hi_we) hi_d = wdata;
      if (lo_we) lo_d = wdata;
    end
  end

  // Register update with synchronous clear
  always_ff @(posedge clk) begin
    if (reset) begin
      hi_q <= '0;
      lo_q <= '0;
    end else begin
      hi_q <= hi_d;
      lo_q <= lo_d;
    end
  end

  assign hi = hi_q;
  assign lo = lo_q;

endmodule

// File: rtl/muldiv_ctrl.sv
// Sequencer for the multi-cycle divider/multiplier feeding architectural HI/LO.
// Latency: start at edge 0 -> INIT c1, RUN c2..N+1, COMMIT cN+2, result from cN+3; div-by-zero traps in c1.
// Backpressure: busy stalls the pipeline; start/MT writes are dropped (not queued) while busy.
module muldiv_ctrl import muldiv_pkg::*; #(
  parameter int unsigned WIDTH       = DEF_WIDTH,
  parameter int unsigned DIV_CYCLES  = DEF_DIV_CYCLES,
  parameter int unsigned MULT_CYCLES = DEF_MULT_CYCLES,
  parameter int unsigned CNT_W       = DEF_CNT_W
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic             op_div,
  input  logic [WIDTH-1:0] src_a,
  input  logic [WIDTH-1:0] src_b,
  input  logic             hi_we,
  input  logic             lo_we,
  input  logic [WIDTH-1:0] wdata,
  output logic             div_init,
  output logic             mult_init,
  output logic [WIDTH-1:0] op_a,
  output logic [WIDTH-1:0] op_b,
  input  logic [WIDTH-1:0] div_hi,
  input  logic [WIDTH-1:0] div_lo,
  input  logic [WIDTH-1:0] mult_hi,
  input  logic [WIDTH-1:0] mult_lo,
  output logic             busy,
  output logic             done,
  output logic             div_zero,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  // Terminal counter values: RUN lasts exactly N cycles (counter 0..N-1)
  localparam logic [CNT_W-1:0] DIV_LAST  = CNT_W'(DIV_CYCLES - 1);
  localparam logic [CNT_W-1:0] MULT_LAST = CNT_W'(MULT_CYCLES - 1);

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [WIDTH-1:0] op_a_q, op_a_d;
  logic [WIDTH-1:0] op_b_q, op_b_d;
  logic             op_div_q, op_div_d;

  logic             is_idle;
  logic             is_commit;
  logic [CNT_W-1:0] run_last;
  logic [WIDTH-1:0] sel_hi;
  logic [WIDTH-1:0] sel_lo;

  // State, counter and latched-operand registers
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      op_a_q   <= '0;
      op_b_q   <= '0;
      op_div_q <= OP_MULT;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      op_a_q   <= op_a_d;
      op_b_q   <= op_b_d;
      op_div_q <= op_div_d;
    end
  end

  assign run_last = (op_div_q == OP_DIV) ? DIV_LAST : MULT_LAST;

  // Next-state, counter and operand-latch logic
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    op_a_d   = op_a_q;
    op_b_d   = op_b_q;
    op_div_d = op_div_q;
    unique case (state_q)
      IDLE: begin
        if (start) begin
          // Trap on the raw denominator so the divider never sees zero
          if (is_div_by_zero(op_div, src_b == '0)) begin
            state_d = EXC;
          end else begin
            op_a_d   = src_a;
            op_b_d   = src_b;
            op_div_d = op_div;
            state_d  = INIT;
          end
        end
      end
      INIT: begin
        cnt_d   = '0;
        state_d = RUN;
      end
      RUN: begin
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == run_last) state_d = COMMIT;
      end
      COMMIT:  state_d = IDLE;
      EXC:     state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  assign is_idle   = (state_q == IDLE);
  assign is_commit = (state_q == COMMIT);

  assign busy      = !is_idle;
  assign done      = is_commit;
  assign div_zero  = (state_q == EXC);
  assign div_init  = (state_q == INIT) && (op_div_q == OP_DIV);
  assign mult_init = (state_q == INIT) && (op_div_q == OP_MULT);
  assign op_a      = op_a_q;
  assign op_b      = op_b_q;

  assign sel_hi = (op_div_q == OP_DIV) ? div_hi : mult_hi;
  assign sel_lo = (op_div_q == OP_DIV) ? div_lo : mult_lo;

  hilo_regs #(
    .WIDTH(WIDTH)
  ) u_hilo (
    .clk      (clk),
    .reset    (reset),
    .commit_en(is_commit),
    .commit_hi(sel_hi),
    .commit_lo(sel_lo),
    .mt_en    (is_idle),
    .hi_we    (hi_we),
    .lo_we    (lo_we),
    .wdata    (wdata),
    .hi       (hi),
    .lo       (lo)
  );

endmodule

// File: tb/tb_muldiv_ctrl.sv
// Self-checking bench for muldiv_ctrl with behavioural divider/multiplier models.
// Latency: n/a.
// Backpressure: n/a.
module tb_muldiv_ctrl;

  localparam int W  = 32;
  localparam int ND = 32;
  localparam int NM = 32;

  logic         clk = 1'b0;
  logic         reset;
  logic         start;
  logic         op_div;
  logic [W-1:0] src_a, src_b;
  logic         hi_we, lo_we;
  logic [W-1:0] wdata;
  logic         div_init, mult_init;
  logic [W-1:0] op_a, op_b;
  logic [W-1:0] div_hi, div_lo, mult_hi, mult_lo;
  logic         busy, done, div_zero;
  logic [W-1:0] hi, lo;

  int checks   = 0;
  int failures = 0;

  // Architectural model of HI/LO
  logic [W-1:0] m_hi = '0;
  logic [W-1:0] m_lo = '0;

  logic [4:0]   flags;
  logic [63:0]  prod;

  always #5 clk = ~clk;

  // Environment models of the two arithmetic units
  assign prod    = 64'(op_a) * 64'(op_b);
  assign mult_hi = prod[63:32];
  assign mult_lo = prod[31:0];
  assign div_hi  = (op_b == '0) ? '0 : (op_a % op_b);
  assign div_lo  = (op_b == '0) ? '0 : (op_a / op_b);

  assign flags = {busy, div_init, mult_init, done, div_zero};

  muldiv_ctrl #(
    .WIDTH(W), .DIV_CYCLES(ND), .MULT_CYCLES(NM), .CNT_W(6)
  ) dut (
    .clk(clk), .reset(reset), .start(start), .op_div(op_div),
    .src_a(src_a), .src_b(src_b), .hi_we(hi_we), .lo_we(lo_we), .wdata(wdata),
    .div_init(div_init), .mult_init(mult_init), .op_a(op_a), .op_b(op_b),
    .div_hi(div_hi), .div_lo(div_lo), .mult_hi(mult_hi), .mult_lo(mult_lo),
    .busy(busy), .done(done), .div_zero(div_zero), .hi(hi), .lo(lo)
  );

  // Advance one cycle; sample point sits 1 time unit after the edge
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Expected {hi,lo} of a completed op, straight from arithmetic
  function automatic logic [63:0] ref_result(input logic is_div, input logic [W-1:0] a,
                                             input logic [W-1:0] b);
    logic [63:0] p;
    if (is_div) return {a % b, a / b};
    p = 64'(a) * 64'(b);
    return p;
  endfunction

  // Issue one op and check every cycle until it retires to IDLE
  task automatic run_op(input string nm, input logic is_div, input logic [W-1:0] a,
                        input logic [W-1:0] b);
    int n;
    logic [4:0]  exp_f;
    logic [63:0] res;
    start = 1'b1; op_div = is_div; src_a = a; src_b = b;
    step();
    start = 1'b0; src_a = $urandom; src_b = $urandom; op_div = $urandom_range(0, 1);
    if (is_div && b == '0) begin
      checks++;
      if (flags !== 5'b10001) begin
        failures++;
        $display("FAIL %s exc_flags got=%b exp=%b", nm, flags, 5'b10001);
      end
      step();
      checks++;
      if ({flags, hi, lo} !== {5'b00000, m_hi, m_lo}) begin
        failures++;
        $display("FAIL %s exc_after got=%b %h %h exp=00000 %h %h", nm, flags, hi, lo, m_hi, m_lo);
      end
    end else begin
      n   = is_div ? ND : NM;
      res = ref_result(is_div, a, b);
      for (int c = 1; c <= n + 2; c++) begin
        if (c > 1) step();
        exp_f = {1'b1, (c == 1) && is_div, (c == 1) && !is_div, c == n + 2, 1'b0};
        checks++;
        if (flags !== exp_f || {hi, lo} !== {m_hi, m_lo}) begin
          failures++;
          $display("FAIL %s cyc%0d flags/hilo got=%b %h %h exp=%b %h %h",
                   nm, c, flags, hi, lo, exp_f, m_hi, m_lo);
        end
        if (c == 1) begin
          checks++;
          if ({op_a, op_b} !== {a, b}) begin
            failures++;
            $display("FAIL %s operands got=%h %h exp=%h %h", nm, op_a, op_b, a, b);
          end
        end
      end
      step();
      {m_hi, m_lo} = res;
      checks++;
      if ({flags, hi, lo} !== {5'b00000, m_hi, m_lo}) begin
        failures++;
        $display("FAIL %s result got=%b %h %h exp=00000 %h %h", nm, flags, hi, lo, m_hi, m_lo);
      end
    end
  endtask

  task automatic test_reset();
    reset = 1'b1; start = 1'b0; op_div = 1'b0; src_a = '1; src_b = '1;
    hi_we = 1'b0; lo_we = 1'b0; wdata = '1;
    step(); step();
    reset = 1'b0;
    m_hi = '0; m_lo = '0;
    checks++;
    if ({flags, hi, lo, op_a, op_b} !== {5'b00000, 128'd0}) begin
      failures++;
      $display("FAIL reset got=%b %h %h %h %h exp=00000 all-zero", flags, hi, lo, op_a, op_b);
    end
  endtask

  task automatic test_div_basic();
    run_op("div_100_7", 1'b1, 32'd100, 32'd7);
    checks++;
    if (hi !== 32'd2 || lo !== 32'd14) begin
      failures++;
      $display("FAIL div_100_7_value got=%0d %0d exp=2 14", hi, lo);
    end
  endtask

  task automatic test_mult_basic();
    run_op("mult_ff_2", 1'b0, 32'hFFFF_FFFF, 32'd2);
    checks++;
    if (hi !== 32'h0000_0001 || lo !== 32'hFFFF_FFFE) begin
      failures++;
      $display("FAIL mult_ff_2_value got=%h %h exp=00000001 fffffffe", hi, lo);
    end
  endtask

  task automatic test_mt_write();
    hi_we = 1'b1; lo_we = 1'b1; wdata = 32'hA5A5_A5A5;
    step();
    hi_we = 1'b0; lo_we = 1'b0;
    checks++;
    if ({busy, hi, lo} !== {1'b0, 32'hA5A5_A5A5, 32'hA5A5_A5A5}) begin
      failures++;
      $display("FAIL mt_both got=%b %h %h exp=0 a5a5a5a5 a5a5a5a5", busy, hi, lo);
    end
    hi_we = 1'b1; wdata = 32'd5;
    step();
    hi_we = 1'b0; lo_we = 1'b1; wdata = 32'd9;
    step();
    lo_we = 1'b0;
    m_hi = 32'd5; m_lo = 32'd9;
    checks++;
    if ({hi, lo} !== {32'd5, 32'd9}) begin
      failures++;
      $display("FAIL mt_single got=%h %h exp=5 9", hi, lo);
    end
  endtask

  task automatic test_div_zero();
    run_op("div_zero", 1'b1, 32'd1234, 32'd0);
  endtask

  task automatic test_ignore_during_run();
    int ndone = 0;
    logic [63:0] res = ref_result(1'b1, 32'd1000, 32'd3);
    start = 1'b1; op_div = 1'b1; src_a = 32'd1000; src_b = 32'd3;
    step();
    start = 1'b0;
    for (int c = 2; c <= ND + 3; c++) begin
      if (c >= 3 && c <= 20) begin
        start = 1'b1; op_div = 1'b0; src_a = $urandom; src_b = $urandom;
        hi_we = 1'b1; lo_we = 1'b1; wdata = $urandom;
      end else begin
        start = 1'b0; hi_we = 1'b0; lo_we = 1'b0;
      end
      step();
      if (done) ndone++;
    end
    {m_hi, m_lo} = res;
    checks++;
    if (ndone != 1 || {busy, hi, lo} !== {1'b0, m_hi, m_lo}) begin
      failures++;
      $display("FAIL ignore_busy got done=%0d busy=%b %h %h exp done=1 busy=0 %h %h",
               ndone, busy, hi, lo, m_hi, m_lo);
    end
  endtask

  task automatic test_mt_with_start();
    logic [W-1:0] a = $urandom;
    logic [W-1:0] b = $urandom;
    logic [W-1:0] wv = $urandom;
    start = 1'b1; op_div = 1'b0; src_a = a; src_b = b;
    hi_we = 1'b1; lo_we = 1'b1; wdata = wv;
    step();
    start = 1'b0; hi_we = 1'b0; lo_we = 1'b0;
    checks++;
    if ({mult_init, hi, lo} !== {1'b1, wv, wv}) begin
      failures++;
      $display("FAIL mt_with_start_write got=%b %h %h exp=1 %h %h", mult_init, hi, lo, wv, wv);
    end
    for (int c = 2; c <= NM + 3; c++) step();
    {m_hi, m_lo} = ref_result(1'b0, a, b);
    checks++;
    if ({busy, hi, lo} !== {1'b0, m_hi, m_lo}) begin
      failures++;
      $display("FAIL mt_with_start_commit got=%b %h %h exp=0 %h %h", busy, hi, lo, m_hi, m_lo);
    end
  endtask

  task automatic test_reset_mid();
    int ndone = 0;
    start = 1'b1; op_div = 1'b1; src_a = 32'd500; src_b = 32'd9;
    step();
    start = 1'b0;
    for (int c = 2; c <= 10; c++) begin
      step();
      if (done) ndone++;
    end
    reset = 1'b1;
    step();
    reset = 1'b0;
    m_hi = '0; m_lo = '0;
    checks++;
    if (ndone != 0 || {flags, hi, lo, op_a, op_b} !== {5'b00000, 128'd0}) begin
      failures++;
      $display("FAIL reset_mid got done=%0d %b %h %h %h %h exp=0 00000 all-zero",
               ndone, flags, hi, lo, op_a, op_b);
    end
    run_op("after_reset", 1'b1, 32'd77, 32'd5);
  endtask

  task automatic test_back_to_back();
    logic         d;
    logic [W-1:0] a, b;
    for (int i = 0; i < 8; i++) begin
      d = $urandom_range(0, 1);
      a = $urandom;
      b = ($urandom_range(0, 3) == 0) ? '0 : W'($urandom);
      if (i == 0) begin d = 1'b1; b = '0; end
      run_op("b2b", d, a, b);
    end
  endtask

  initial begin
    test_reset();
    test_div_basic();
    test_mult_basic();
    test_mt_write();
    test_div_zero();
    test_ignore_during_run();
    test_mt_with_start();
    test_reset_mid();
    test_back_to_back();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
